// File: rtl/mips_pkg.sv
// Shared types and widths for the memory arbiter: FSM states, requester ids, word geometry.
package mips_pkg;

    localparam int MEM_WORD_W = 32;
    localparam int MEM_BE_W   = MEM_WORD_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2,
        ARB_RESP   = 2'd3
    } t_arb_state;

    typedef enum logic {
        ARB_SRC_I = 1'b0,
        ARB_SRC_D = 1'b1
    } t_arb_src;

    function automatic t_arb_state busy_state(input t_arb_src src);
        return (src == ARB_SRC_D) ? ARB_D_BUSY : ARB_I_BUSY;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and backing-memory signals of the arbiter; slave = arbiter view, master = core/memory view.
interface mem_arbiter_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
);

    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_done;
    logic [MEM_WORD_W-1:0] i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [MEM_WORD_W-1:0] d_wdata;
    logic [MEM_BE_W-1:0]   d_be;
    logic                  d_done;
    logic [MEM_WORD_W-1:0] d_rdata;

    logic                  m_req;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [MEM_WORD_W-1:0] m_wdata;
    logic [MEM_BE_W-1:0]   m_be;
    logic                  m_ack;
    logic [MEM_WORD_W-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  m_ack, m_rdata,
        output i_done, i_rdata,
        output d_done, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_be
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output m_ack, m_rdata,
        input  i_done, i_rdata,
        input  d_done, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_be
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_RR_EN: tie goes to the requester not granted last; otherwise data always wins a tie.
module arb_pick
    import mips_pkg::*;
(
    input  logic     i_req,
    input  logic     d_req,
    input  t_arb_src last_grant,
    output t_arb_src winner
);

    always_comb begin
        winner = ARB_SRC_I;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            winner = (last_grant == ARB_SRC_I) ? ARB_SRC_D : ARB_SRC_I;
`else
            winner = ARB_SRC_D;
`endif
        end else if (d_req) begin
            winner = ARB_SRC_D;
        end
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority has no use for history; keep the port so both builds share one interface.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// One-at-a-time arbiter of the shared memory port between fetch and load/store; all outputs registered.
// MEM_ARB_RR_EN selects round-robin tie-breaking (builds the last-grant register); default is data-first.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    t_arb_state            state;
    t_arb_src              winner;
    t_arb_src              last_grant;

    logic                  m_req_r;
    logic                  m_we_r;
    logic [ADDR_W-1:0]     m_addr_r;
    logic [MEM_WORD_W-1:0] m_wdata_r;
    logic [MEM_BE_W-1:0]   m_be_r;
    logic                  i_done_r;
    logic                  d_done_r;
    logic [MEM_WORD_W-1:0] i_rdata_r;
    logic [MEM_WORD_W-1:0] d_rdata_r;

    arb_pick u_pick (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .last_grant (last_grant),
        .winner     (winner)
    );

`ifndef MEM_ARB_RR_EN
    assign last_grant = ARB_SRC_I;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            m_req_r   <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= '0;
            m_wdata_r <= '0;
            m_be_r    <= '0;
            i_done_r  <= 1'b0;
            d_done_r  <= 1'b0;
            i_rdata_r <= '0;
            d_rdata_r <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant <= ARB_SRC_I;
`endif
        end else begin
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        m_req_r <= 1'b1;
                        state   <= busy_state(winner);
`ifdef MEM_ARB_RR_EN
                        last_grant <= winner;
`endif
                        if (winner == ARB_SRC_D) begin
                            m_we_r    <= bus.d_we;
                            m_addr_r  <= bus.d_addr;
                            m_wdata_r <= bus.d_wdata;
                            m_be_r    <= bus.d_be;
                        end else begin
                            m_we_r    <= 1'b0;
                            m_addr_r  <= bus.i_addr;
                            m_wdata_r <= '0;
                            m_be_r    <= '1;
                        end
                    end
                end
                ARB_I_BUSY: begin
                    if (bus.m_ack) begin
                        m_req_r   <= 1'b0;
                        i_rdata_r <= bus.m_rdata;
                        i_done_r  <= 1'b1;
                        state     <= ARB_RESP;
                    end
                end
                ARB_D_BUSY: begin
                    if (bus.m_ack) begin
                        m_req_r  <= 1'b0;
                        d_done_r <= 1'b1;
                        state    <= ARB_RESP;
                        // Stores leave the previous load word visible.
                        if (!m_we_r) begin
                            d_rdata_r <= bus.m_rdata;
                        end
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.m_req   = m_req_r;
    assign bus.m_we    = m_we_r;
    assign bus.m_addr  = m_addr_r;
    assign bus.m_wdata = m_wdata_r;
    assign bus.m_be    = m_be_r;
    assign bus.i_done  = i_done_r;
    assign bus.i_rdata = i_rdata_r;
    assign bus.d_done  = d_done_r;
    assign bus.d_rdata = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions, directed tie/reset/stray-ack sequences, randomized traffic.
module tb_mem_arbiter;
    import mips_pkg::*;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] exp_rdata;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    bit          mem_auto = 1'b0;
    int          mem_wait = 0;
    bit          rand_wait = 1'b0;
    bit          rand_phase = 1'b0;
    int          i_cnt = 0;
    int          d_cnt = 0;
    byte         glog[$];
    t_arb_src    model_last = ARB_SRC_I;
    logic        cap_we = 1'b0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_be = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory contents as seen by the bench; address 0x10 holds a known instruction word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // Memory responder plus protocol monitor, evaluated 1 time unit after each rising edge.
    initial begin : env
        logic        last_mreq;
        logic        hit;
        logic        ew;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [4:0]  s_webe;
        int          wcnt;
        last_mreq = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_webe    = '0;
        wcnt      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last_mreq = 1'b0;
                wcnt      = 0;
                if (mem_auto) bus.m_ack = 1'b0;
                continue;
            end
            hit = bus.m_ack && last_mreq;
            if (hit || bus.i_done || bus.d_done) begin
                chk("done_after_ack", 32'(bus.i_done) + 32'(bus.d_done), 32'(hit));
                if (rand_phase && hit) chk("done_kind", 32'(bus.d_done), 32'(s_addr[31]));
            end
            if (bus.i_done) begin i_cnt++; glog.push_back("I"); end
            if (bus.d_done) begin d_cnt++; glog.push_back("D"); end
            if (bus.m_req && !last_mreq) begin
                s_addr  = bus.m_addr;
                s_wdata = bus.m_wdata;
                s_webe  = {bus.m_we, bus.m_be};
                if (rand_phase) begin
                    if (bus.i_req && bus.d_req) begin
`ifdef MEM_ARB_RR_EN
                        ew = (model_last == ARB_SRC_I);
`else
                        ew = 1'b1;
`endif
                    end else begin
                        ew = bus.d_req;
                    end
                    chk("grant_winner", 32'(bus.m_addr[31]), 32'(ew));
                    model_last = ew ? ARB_SRC_D : ARB_SRC_I;
                end
            end else if (bus.m_req && last_mreq) begin
                chk("m_addr_stable", bus.m_addr, s_addr);
                chk("m_wdata_stable", bus.m_wdata, s_wdata);
                chk("m_we_be_stable", 32'({bus.m_we, bus.m_be}), 32'(s_webe));
            end
            if (mem_auto) begin
                if (bus.m_ack) begin
                    bus.m_ack = 1'b0;
                end else if (bus.m_req) begin
                    if (wcnt >= mem_wait) begin
                        bus.m_ack   = 1'b1;
                        bus.m_rdata = bus.m_we ? 32'hBAD0_BAD0 : mem_word(bus.m_addr);
                        cap_we      = bus.m_we;
                        cap_addr    = bus.m_addr;
                        cap_wdata   = bus.m_wdata;
                        cap_be      = bus.m_be;
                        wcnt        = 0;
                        if (rand_wait) mem_wait = $urandom_range(0, 3);
                    end else begin
                        wcnt++;
                    end
                end
            end
            last_mreq = bus.m_req;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_done(input bit dside, input int maxc, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(dside ? bus.d_done : bus.i_done) && lat < maxc);
        if (!(dside ? bus.d_done : bus.i_done)) lat = -1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        bus.i_req  = 1'b0;
        bus.d_req  = 1'b0;
        bus.m_ack  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int i0;
        int d0;
        mem_wait = v.waits;
        i0 = i_cnt;
        d0 = d_cnt;
        @(negedge clk);
        if (v.fetch) begin
            bus.i_addr = v.addr;
            bus.i_req  = 1'b1;
        end else begin
            bus.d_we    = v.we;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
            bus.d_be    = v.be;
            bus.d_req   = 1'b1;
        end
        wait_done(!v.fetch, 50, lat);
        chk({v.name, "_latency"}, 32'(lat), 32'(v.waits + 2));
        if (v.fetch) chk({v.name, "_i_rdata"}, bus.i_rdata, v.exp_rdata);
        else         chk({v.name, "_d_rdata"}, bus.d_rdata, v.exp_rdata);
        chk({v.name, "_m_addr"}, cap_addr, v.addr);
        chk({v.name, "_m_we"}, 32'(cap_we), v.fetch ? 32'd0 : 32'(v.we));
        if (v.fetch) begin
            chk({v.name, "_m_be"}, 32'(cap_be), 32'hF);
            chk({v.name, "_m_wdata"}, cap_wdata, 32'h0);
        end else if (v.we) begin
            chk({v.name, "_m_be"}, 32'(cap_be), 32'(v.be));
            chk({v.name, "_m_wdata"}, cap_wdata, v.wdata);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (3) @(negedge clk);
        chk({v.name, "_i_done_count"}, 32'(i_cnt - i0), v.fetch ? 32'd1 : 32'd0);
        chk({v.name, "_d_done_count"}, 32'(d_cnt - d0), v.fetch ? 32'd0 : 32'd1);
    endtask

    task automatic tie_test();
        string exp_s;
        int    nd;
        int    ni;
`ifdef MEM_ARB_RR_EN
        exp_s = "DIDI";
        nd = 2;
        ni = 2;
`else
        exp_s = "DDDI";
        nd = 3;
        ni = 1;
`endif
        apply_reset();
        mem_wait = 0;
        glog.delete();
        fork
            begin : data_side
                int lat;
                for (int n = 0; n < nd; n++) begin
                    bus.d_we   = 1'b0;
                    bus.d_addr = 32'h200 + n * 4;
                    bus.d_req  = 1'b1;
                    wait_done(1'b1, 60, lat);
                    if (lat < 0) begin chk("tie_data_timeout", 32'd1, 32'd0); break; end
                end
                bus.d_req = 1'b0;
            end
            begin : fetch_side
                int lat;
                for (int n = 0; n < ni; n++) begin
                    bus.i_addr = 32'h100 + n * 4;
                    bus.i_req  = 1'b1;
                    wait_done(1'b0, 60, lat);
                    if (lat < 0) begin chk("tie_fetch_timeout", 32'd1, 32'd0); break; end
                end
                bus.i_req = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("tie_grant_count", 32'(glog.size()), 32'(exp_s.len()));
        for (int k = 0; k < exp_s.len(); k++) begin
            chk($sformatf("tie_order_%0d", k), 32'((k < glog.size()) ? glog[k] : 8'h00), 32'(exp_s[k]));
        end
    endtask

    task automatic random_phase();
        apply_reset();
        model_last = ARB_SRC_I;
        mem_wait   = $urandom_range(0, 3);
        rand_wait  = 1'b1;
        rand_phase = 1'b1;
        fork
            begin : rnd_fetch
                logic [31:0] a;
                int          lat;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    a = $urandom & 32'h7FFF_FFFC;
                    bus.i_addr = a;
                    bus.i_req  = 1'b1;
                    wait_done(1'b0, 2000, lat);
                    if (lat < 0) begin chk("rnd_fetch_timeout", 32'd1, 32'd0); bus.i_req = 1'b0; break; end
                    chk("rnd_fetch_rdata", bus.i_rdata, mem_word(a));
                    chk("rnd_fetch_addr", cap_addr, a);
                    chk("rnd_fetch_we_be", 32'({cap_we, cap_be}), 32'h0F);
                    bus.i_req = 1'b0;
                end
            end
            begin : rnd_data
                logic [31:0] a;
                logic [31:0] wd;
                logic [31:0] last_load;
                logic [3:0]  be;
                logic        we;
                int          lat;
                last_load = '0;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    a  = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
                    wd = $urandom;
                    be = 4'($urandom_range(1, 15));
                    we = 1'($urandom_range(0, 1));
                    bus.d_addr  = a;
                    bus.d_wdata = wd;
                    bus.d_be    = be;
                    bus.d_we    = we;
                    bus.d_req   = 1'b1;
                    wait_done(1'b1, 2000, lat);
                    if (lat < 0) begin chk("rnd_data_timeout", 32'd1, 32'd0); bus.d_req = 1'b0; break; end
                    chk("rnd_data_addr", cap_addr, a);
                    chk("rnd_data_we", 32'(cap_we), 32'(we));
                    if (we) begin
                        chk("rnd_store_wdata", cap_wdata, wd);
                        chk("rnd_store_be", 32'(cap_be), 32'(be));
                    end else begin
                        last_load = mem_word(a);
                    end
                    chk("rnd_data_rdata", bus.d_rdata, last_load);
                    bus.d_req = 1'b0;
                end
            end
        join
        rand_phase = 1'b0;
        rand_wait  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin : main
        vec_t vt[6];
        vec_t post_rst;
        int   i0;
        int   d0;
        int   to;

        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_be    = '0;
        bus.m_ack   = 1'b0;
        bus.m_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_state", 32'(dut.state), 32'(ARB_IDLE));
        chk("rst_m_req", 32'(bus.m_req), 32'd0);
        chk("rst_m_we", 32'(bus.m_we), 32'd0);
        chk("rst_m_addr", bus.m_addr, 32'd0);
        chk("rst_m_wdata", bus.m_wdata, 32'd0);
        chk("rst_m_be", 32'(bus.m_be), 32'd0);
        chk("rst_i_done", 32'(bus.i_done), 32'd0);
        chk("rst_d_done", 32'(bus.d_done), 32'd0);
        chk("rst_i_rdata", bus.i_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        rst      = 1'b0;
        mem_auto = 1'b1;

        vt[0] = '{"fetch_zero_wait", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 32'h2008_0005};
        vt[1] = '{"load_one_wait",   1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'hF, 1, mem_word(32'h44)};
        vt[2] = '{"store_wait3",     1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011, 3, mem_word(32'h44)};
        vt[3] = '{"fetch_wait2",     1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 2, mem_word(32'h1000)};
        vt[4] = '{"load_zero_wait",  1'b0, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 0, mem_word(32'h80)};
        vt[5] = '{"fetch_top_addr",  1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 5, mem_word(32'hFFFF_FFFC)};
        for (int k = 0; k < 6; k++) run_vec(vt[k]);

        tie_test();

        // Reset while a store is stalled in the data busy state.
        mem_wait = 10;
        @(negedge clk);
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h300;
        bus.d_wdata = 32'h1234_5678;
        bus.d_be    = 4'hF;
        bus.d_req   = 1'b1;
        to = 0;
        while (!bus.m_req && to < 20) begin @(negedge clk); to++; end
        @(negedge clk);
        chk("midrst_busy", 32'(dut.state), 32'(ARB_D_BUSY));
        i0 = i_cnt;
        d0 = d_cnt;
        rst = 1'b1;
        #1;
        chk("midrst_m_req", 32'(bus.m_req), 32'd0);
        chk("midrst_state", 32'(dut.state), 32'(ARB_IDLE));
        bus.d_req = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        mem_wait = 0;
        repeat (4) @(negedge clk);
        chk("midrst_no_i_done", 32'(i_cnt - i0), 32'd0);
        chk("midrst_no_d_done", 32'(d_cnt - d0), 32'd0);
        post_rst = '{"fetch_after_rst", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1, mem_word(32'h20)};
        run_vec(post_rst);

        // Stray ack in idle must not complete anything or disturb read data.
        mem_auto = 1'b0;
        i0 = i_cnt;
        d0 = d_cnt;
        @(negedge clk);
        chk("stray_idle", 32'(dut.state), 32'(ARB_IDLE));
        bus.m_rdata = 32'hFFFF_FFFF;
        bus.m_ack   = 1'b1;
        @(negedge clk);
        bus.m_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_i_done", 32'(i_cnt - i0), 32'd0);
        chk("stray_d_done", 32'(d_cnt - d0), 32'd0);
        chk("stray_i_rdata", bus.i_rdata, mem_word(32'h20));
        chk("stray_d_rdata", bus.d_rdata, 32'd0);
        chk("stray_m_req", 32'(bus.m_req), 32'd0);
        mem_auto = 1'b1;

        random_phase();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single memory port between the MIPS instruction-fetch path and the load/store data path. It accepts one request at a time from each requester, chooses a winner, and drives a req/ack transaction on the backing memory. It then returns read data to the winner with a one-cycle done pulse. It sits between the core's fetch and memory stages and the unified byte-addressable memory, and is the core's only way to reach memory.

## Interface
- ADDR_W, 32, byte address width on all ports
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request; held high, with i_addr stable, until i_done
- i_addr  in  ADDR_W  fetch byte address (read only)
- i_done  out  1  one-cycle pulse; i_rdata valid in the same cycle
- i_rdata  out  32  fetched word, held until the next i_done
- d_req  in  1  data request; held high, with d_we/d_addr/d_wdata/d_be stable, until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables; ignored on loads
- d_done  out  1  one-cycle pulse; d_rdata valid on loads
- d_rdata  out  32  load word, held until the next d_done; unchanged by stores
- m_req  out  1  memory request; held until m_ack
- m_we, m_addr, m_wdata, m_be  out  1/ADDR_W/32/4  latched command fields, stable while m_req=1
- m_ack  in  1  memory completion; m_rdata valid in the same cycle; ignored when m_req=0
- m_rdata  in  32  memory read data

## Operation
- The FSM has four states: ARB_IDLE, ARB_I_BUSY, ARB_D_BUSY, ARB_RESP.
- In ARB_IDLE with no request, the FSM stays in ARB_IDLE.
- In ARB_IDLE with a request:
  - The FSM picks a winner.
  - It latches the winner's fields into the m_* registers.
  - It sets m_req=1 and moves to ARB_I_BUSY or ARB_D_BUSY.
- Fetch commands always drive m_we=0 and m_be=4'hF. i_addr is copied into m_addr, and m_wdata is 0.
- In a BUSY state:
  - The FSM waits for m_ack, with any number of wait cycles.
  - On m_ack it clears m_req, captures m_rdata into the winner's rdata register (loads and fetches only), and pulses the winner's done in the next cycle.
  - It then moves to ARB_RESP.
- ARB_RESP always moves to ARB_IDLE. This one-cycle gap lets the requester drop or change its request before it is sampled again.
- Requests arriving while the arbiter is busy wait in their requester; they are not queued internally.
- Priority when both requests are high in ARB_IDLE depends on the build (see Configuration).
- A request that is lowered before its done is a protocol violation, and the behaviour is undefined.

## Timing
- Reset values:
  - State is ARB_IDLE.
  - m_req, m_we, m_addr, m_wdata, m_be, i_done, d_done, i_rdata and d_rdata are all 0.
  - The last-grant register is set to "fetch".
- All outputs are registered; no output depends combinationally on an input.
- Request sampled at edge N gives m_req=1 from cycle N. m_ack in cycle N+k (k≥0 wait cycles) gives done=1 in cycle N+k+1. Best case is done two cycles after the request is first high.
- Best-case back-to-back spacing is a new m_req every 3 cycles.
- Asserting reset mid-transaction:
  - m_req drops immediately and done is never issued.
  - The memory must tolerate the abandoned request.
- m_ack while in ARB_IDLE or ARB_RESP is ignored.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, the requester that was not granted last wins.
  - Since reset leaves last-grant at "fetch", data wins the first tie.
  - The last-grant register updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, data always wins a tie.
  - Fetch can starve under continuous data traffic; this is accepted because the single-issue core does not issue a new load/store without a fetch.
  - The last-grant register is not built.

## Structure
- mips_pkg holds:
  - typedef t_arb_state, with the four states above;
  - typedef t_arb_src, with ARB_SRC_I and ARB_SRC_D;
  - localparam MEM_WORD_W = 32.
- Sub-module arb_pick is combinational. Inputs: i_req, d_req, last_grant. Output: the winning t_arb_src. The MEM_ARB_RR_EN selection lives only in arb_pick.
- The register file, ALU and memory arrays stay outside this block.

## Test plan
- Single fetch, zero wait:
  - Stimulus: i_req=1, i_addr=0x10; memory returns m_ack in the first m_req cycle with m_rdata=0x2008_0005.
  - Required: m_addr=0x10 and m_we=0; i_done pulses exactly once with i_rdata=0x2008_0005, two cycles after i_req rose.
- Store with wait states:
  - Stimulus: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEAD_BEEF, d_be=4'b0011; m_ack after 3 wait cycles.
  - Required: m_* fields are stable for 4 cycles; d_done pulses; d_rdata stays at its previous value; i_done stays 0.
- Tie, fixed priority (macro undefined):
  - Stimulus: i_req and d_req rise together, both held.
  - Required: data is served first, then fetch; three back-to-back data requests keep fetch waiting.
- Tie, round-robin (MEM_ARB_RR_EN defined):
  - Stimulus: both requests held continuously for 4 transactions.
  - Required: grant order is D, I, D, I.
- Reset mid-transaction:
  - Stimulus: assert rst while in ARB_D_BUSY, before m_ack.
  - Required: m_req=0 immediately; no done pulse; the FSM is in ARB_IDLE; a later fetch completes normally.
- Stray ack:
  - Stimulus: pulse m_ack while in ARB_IDLE with m_rdata=0xFFFF_FFFF.
  - Required: no done pulse, and i_rdata/d_rdata are unchanged.
